// File: rtl/wb_grf_pkg.sv
// Shared types and constants for the write-back stage and its register file.
package wb_grf_pkg;

  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam logic [31:0] PC_LINK_OFFSET = 32'd8;
  localparam logic [31:0] RESET_PC       = 32'h0000_3000;
  localparam int unsigned GRF_DEPTH      = 32;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

endpackage

// File: rtl/wb_grf_if.sv
// WB-stage bundle, ID-stage read ports and commit trace between the pipeline and wb_grf.
interface wb_grf_if
  import wb_grf_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  logic             stall;
  word_t            wb_pc;
  reg_addr_t        wb_regaddr;
  word_t            wb_alures;
  word_t            wb_memres;
  logic             wb_memToReg;
  logic             wb_regWrite;
  logic             wb_jump;
  reg_addr_t        rs_addr;
  reg_addr_t        rt_addr;
  word_t            rs_data;
  word_t            rt_data;
  logic             trace_valid;
  word_t            trace_pc;
  reg_addr_t        trace_addr;
  word_t            trace_data;
  logic [CNT_W-1:0] commit_cnt;

  modport master (
    output stall, wb_pc, wb_regaddr, wb_alures, wb_memres,
           wb_memToReg, wb_regWrite, wb_jump, rs_addr, rt_addr,
    input  rs_data, rt_data, trace_valid, trace_pc, trace_addr,
           trace_data, commit_cnt
  );

  modport slave (
    input  stall, wb_pc, wb_regaddr, wb_alures, wb_memres,
           wb_memToReg, wb_regWrite, wb_jump, rs_addr, rt_addr,
    output rs_data, rt_data, trace_valid, trace_pc, trace_addr,
           trace_data, commit_cnt
  );

endinterface

// File: rtl/wb_grf_core.sv
// 32x32 register storage: one synchronous write port, two asynchronous read ports, r0 tied to zero.
module grf_core
  import wb_grf_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  reg_addr_t raddr_a,
  input  reg_addr_t raddr_b,
  output word_t     rdata_a,
  output word_t     rdata_b
);

  word_t regs [GRF_DEPTH];

  // NOTE: this array is a flop-based register file whose architectural state must be zero after
  // reset, so it is cleared explicitly; a RAM macro would not be reset like this.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < GRF_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == REG_ZERO) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == REG_ZERO) ? '0 : regs[raddr_b];

endmodule

// File: rtl/wb_grf.sv
// Write-back stage: selects write data, commits it exactly once per WB bundle, and serves
// bypassed register reads plus a commit trace and counter.
module wb_grf #(
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] PC_LINK_OFFSET = wb_grf_pkg::PC_LINK_OFFSET
) (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);

  import wb_grf_pkg::*;

  logic             fresh_q;
  logic             we;
  word_t            wdata;
  word_t            core_rs;
  word_t            core_rt;
  logic [CNT_W-1:0] commit_cnt_q;

  // A bundle held by stall is committed on its first cycle only; fresh drops while it is held.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fresh_q <= 1'b1;
    end else begin
      fresh_q <= ~bus.stall;
    end
  end

  // NOTE: each combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    wdata = bus.wb_alures;
    if (bus.wb_jump) begin
      wdata = bus.wb_pc + PC_LINK_OFFSET;
    end else if (bus.wb_memToReg) begin
      wdata = bus.wb_memres;
    end
  end

  assign we = fresh_q & bus.wb_regWrite & (bus.wb_regaddr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_cnt_q <= '0;
    end else if (we) begin
      commit_cnt_q <= commit_cnt_q + 1'b1;
    end
  end

  grf_core u_core (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (bus.wb_regaddr),
    .wdata   (wdata),
    .raddr_a (bus.rs_addr),
    .raddr_b (bus.rt_addr),
    .rdata_a (core_rs),
    .rdata_b (core_rt)
  );

  // Write-through: a read of the register being committed this cycle sees the new value.
  always_comb begin
    bus.rs_data = core_rs;
    if (bus.rs_addr == REG_ZERO) begin
      bus.rs_data = '0;
    end else if (we && (bus.rs_addr == bus.wb_regaddr)) begin
      bus.rs_data = wdata;
    end
  end

  always_comb begin
    bus.rt_data = core_rt;
    if (bus.rt_addr == REG_ZERO) begin
      bus.rt_data = '0;
    end else if (we && (bus.rt_addr == bus.wb_regaddr)) begin
      bus.rt_data = wdata;
    end
  end

  assign bus.trace_valid = we;
  assign bus.trace_pc    = bus.wb_pc;
  assign bus.trace_addr  = bus.wb_regaddr;
  assign bus.trace_data  = wdata;
  assign bus.commit_cnt  = commit_cnt_q;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: vector table, commit scoreboard, stall/reset sequences and a
// narrow-counter instance for the wrap case.
module tb_wb_grf;

  import wb_grf_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      stall;
  word_t     pc;
  reg_addr_t regaddr;
  word_t     alures;
  word_t     memres;
  logic      mem_to_reg;
  logic      reg_write;
  logic      jump;
  reg_addr_t rs_addr;
  reg_addr_t rt_addr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cnt_exp  = 0;

  always #5 clk = ~clk;

  wb_grf_if #(.CNT_W(32)) bus   ();
  wb_grf_if #(.CNT_W(2))  bus_w ();

  assign bus.stall         = stall;
  assign bus.wb_pc         = pc;
  assign bus.wb_regaddr    = regaddr;
  assign bus.wb_alures     = alures;
  assign bus.wb_memres     = memres;
  assign bus.wb_memToReg   = mem_to_reg;
  assign bus.wb_regWrite   = reg_write;
  assign bus.wb_jump       = jump;
  assign bus.rs_addr       = rs_addr;
  assign bus.rt_addr       = rt_addr;
  assign bus_w.stall       = stall;
  assign bus_w.wb_pc       = pc;
  assign bus_w.wb_regaddr  = regaddr;
  assign bus_w.wb_alures   = alures;
  assign bus_w.wb_memres   = memres;
  assign bus_w.wb_memToReg = mem_to_reg;
  assign bus_w.wb_regWrite = reg_write;
  assign bus_w.wb_jump     = jump;
  assign bus_w.rs_addr     = rs_addr;
  assign bus_w.rt_addr     = rt_addr;

  wb_grf #(.CNT_W(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
  wb_grf #(.CNT_W(2))  dut_w (.clk(clk), .reset(reset), .bus(bus_w));

  typedef struct {
    logic      jump;
    logic      mtr;
    logic      rw;
    word_t     pc;
    reg_addr_t addr;
    word_t     alu;
    word_t     mem;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      exp_tv;
    word_t     exp_td;
    word_t     exp_rs;
    word_t     exp_rt;
  } vec_t;

  typedef struct {
    reg_addr_t addr;
    word_t     data;
  } commit_t;

  vec_t    vecs [8];
  commit_t sb [$];

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bubble();
    jump       = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc         = RESET_PC;
    regaddr    = '0;
    alures     = '0;
    memres     = '0;
  endtask

  task automatic write_alu(input reg_addr_t a, input word_t d);
    jump       = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b1;
    regaddr    = a;
    alures     = d;
    memres     = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name);
    check({name, "_cnt"}, bus.commit_cnt, cnt_exp);
    check({name, "_cnt_w2"}, {30'd0, bus_w.commit_cnt}, cnt_exp & 32'd3);
  endtask

  task automatic drain_sb();
    commit_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bubble();
      rs_addr = e.addr;
      #1;
      check($sformatf("sb_r%0d", e.addr), bus.rs_data, e.data);
    end
  endtask

  initial begin
    //         jump  mtr   rw    pc             addr   alu            mem            rs     rt     tv    td             rs             rt
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_3000, 5'd5,  32'h1234_5678, 32'h0,         5'd5,  5'd0,  1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_3010, 5'd31, 32'h0000_0001, 32'hAAAA_0000, 5'd31, 5'd5,  1'b1, 32'h0000_3018, 32'h0000_3018, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_3020, 5'd8,  32'hDEAD_BEEF, 32'h0,         5'd8,  5'd8,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_3024, 5'd0,  32'hFFFF_FFFF, 32'h0,         5'd0,  5'd8,  1'b0, 32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_3028, 5'd12, 32'h1111_1111, 32'hCAFE_F00D, 5'd12, 5'd31, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0000_3018};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_302C, 5'd12, 32'h0,         32'h0,         5'd12, 5'd5,  1'b0, 32'h0,         32'hCAFE_F00D, 32'h1234_5678};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 5'd3,  32'h0,         32'h0,         5'd3,  5'd3,  1'b1, 32'h0000_0004, 32'h0000_0004, 32'h0000_0004};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h0000_3030, 5'd5,  32'h0000_0055, 32'h0,         5'd5,  5'd5,  1'b1, 32'h0000_0055, 32'h0000_0055, 32'h0000_0055};

    reset   = 1'b1;
    stall   = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
    bubble();
    step();
    step();
    reset = 1'b0;
    #1;

    // Reset state: every register reads zero, nothing committed.
    for (int r = 0; r < 32; r++) begin
      rs_addr = reg_addr_t'(r);
      rt_addr = reg_addr_t'(31 - r);
      #1;
      check($sformatf("rst_rs_r%0d", r), bus.rs_data, 32'h0);
      check($sformatf("rst_rt_r%0d", 31 - r), bus.rt_data, 32'h0);
    end
    check("rst_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
    check_cnt("rst");

    // Table-driven single-cycle commits.
    for (int i = 0; i < 8; i++) begin
      jump       = vecs[i].jump;
      mem_to_reg = vecs[i].mtr;
      reg_write  = vecs[i].rw;
      pc         = vecs[i].pc;
      regaddr    = vecs[i].addr;
      alures     = vecs[i].alu;
      memres     = vecs[i].mem;
      rs_addr    = vecs[i].rs;
      rt_addr    = vecs[i].rt;
      stall      = 1'b0;
      #1;
      check($sformatf("v%0d_trace_valid", i), {31'd0, bus.trace_valid}, {31'd0, vecs[i].exp_tv});
      check($sformatf("v%0d_trace_data", i), bus.trace_data, vecs[i].exp_td);
      check($sformatf("v%0d_trace_pc", i), bus.trace_pc, vecs[i].pc);
      check($sformatf("v%0d_rs", i), bus.rs_data, vecs[i].exp_rs);
      check($sformatf("v%0d_rt", i), bus.rt_data, vecs[i].exp_rt);
      if (vecs[i].exp_tv) begin
        sb.push_back('{vecs[i].addr, vecs[i].exp_td});
      end
      step();
      if (vecs[i].exp_tv) begin
        cnt_exp++;
      end
      check_cnt($sformatf("v%0d", i));
      drain_sb();
    end

    // Stall holds a write of r9 for three edges: exactly one commit.
    write_alu(5'd9, 32'd7);
    stall   = 1'b1;
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    #1;
    check("stall_c0_trace_valid", {31'd0, bus.trace_valid}, 32'd1);
    check("stall_c0_rs_bypass", bus.rs_data, 32'd7);
    sb.push_back('{5'd9, 32'd7});
    step();
    cnt_exp++;
    check("stall_c1_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
    check("stall_c1_rt_stored", bus.rt_data, 32'd7);
    check_cnt("stall_c1");
    step();
    check("stall_c2_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
    check_cnt("stall_c2");
    step();
    check_cnt("stall_c3");
    stall = 1'b0;
    bubble();
    step();
    check_cnt("stall_release");
    drain_sb();

    // Reset during the second cycle of a stalled write discards everything.
    write_alu(5'd10, 32'h99);
    stall = 1'b1;
    #1;
    check("rstmid_c0_trace_valid", {31'd0, bus.trace_valid}, 32'd1);
    step();
    cnt_exp++;
    check_cnt("rstmid_c1");
    rs_addr = 5'd10;
    #1;
    check("rstmid_c1_r10", bus.rs_data, 32'h99);
    reset = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;
    bubble();
    cnt_exp = 0;
    rs_addr = 5'd9;
    rt_addr = 5'd10;
    #1;
    check("rstmid_r9", bus.rs_data, 32'h0);
    check("rstmid_r10", bus.rt_data, 32'h0);
    check("rstmid_trace_valid", {31'd0, bus.trace_valid}, 32'd0);
    check_cnt("rstmid");

    // Reset wins over a simultaneous commit; a later commit then lands normally.
    reset = 1'b1;
    write_alu(5'd11, 32'h77);
    step();
    reset = 1'b0;
    bubble();
    rs_addr = 5'd11;
    #1;
    check("rstdom_r11", bus.rs_data, 32'h0);
    check_cnt("rstdom");
    write_alu(5'd11, 32'h77);
    sb.push_back('{5'd11, 32'h77});
    step();
    cnt_exp++;
    check_cnt("post_rst");
    drain_sb();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
